full_adder_4bit: RTL and testbench

//   4-bit binary adder with carry-in and carry-out, built as a ripple-carry

---
 rtl/full_adder_4bit_if.sv | 11 +
 rtl/full_adder_4bit.sv | 62 ++++++
 tb/tb_full_adder_4bit.sv | 116 +++++++++++
 3 files changed

// File: rtl/full_adder_4bit_if.sv
// rtl/full_adder_4bit_if.sv - operand/result bundle for the registered 4-bit ripple adder
interface full_adder_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       co;

  modport master (output a, output b, output cin, input sum, input co);
  modport slave  (input a, input b, input cin, output sum, output co);
endinterface

// File: rtl/full_adder_4bit.sv
// rtl/full_adder_4bit.sv - 4-bit ripple-carry adder of full-adder cells, result registered (1-cycle latency)
module full_adder_4bit_half (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// One full-adder cell: two half adders, carry terms ORed.
module full_adder_4bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  logic g;
  logic t;

  full_adder_4bit_half u_ha0 (.x(a), .y(b),  .s(p), .c(g));
  full_adder_4bit_half u_ha1 (.x(p), .y(ci), .s(s), .c(t));

  assign co = g | t;
endmodule

module full_adder_4bit (
  input  logic              clk,
  input  logic              reset,
  full_adder_4bit_if.slave  bus
);
  localparam int WIDTH = 4;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_4bit_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Reset wins over the freshly computed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sum <= '0;
      bus.co  <= 1'b0;
    end else begin
      bus.sum <= s;
      bus.co  <= c[WIDTH];
    end
  end
endmodule

// File: tb/tb_full_adder_4bit.sv
// tb/tb_full_adder_4bit.sv - scoreboard bench: driver queues expected {co,sum}, monitor checks one edge later
module tb_full_adder_4bit;
  logic clk;
  logic reset;

  full_adder_4bit_if fa_if ();

  full_adder_4bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q[$];
  int         id_q[$];
  logic [4:0] last_exp;
  logic       have_last = 1'b0;

  // Monitor: the register updates on every edge, so one queued entry per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      logic [4:0] e;
      int         id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      n_vec++;
      if ({fa_if.co, fa_if.sum} !== e) begin
        n_err++;
        $display("FAIL result id=%0d got co,sum=%b_%b want %b_%b",
                 id, fa_if.co, fa_if.sum, e[4], e[3:0]);
      end
    end
  end

  task automatic check_hold(input int id);
    n_vec++;
    if ({fa_if.co, fa_if.sum} !== last_exp) begin
      n_err++;
      $display("FAIL hold id=%0d got co,sum=%b_%b want %b_%b",
               id, fa_if.co, fa_if.sum, last_exp[4], last_exp[3:0]);
    end
  endtask

  // Drive a vector between edges; wiggle inputs first to show outputs ignore them.
  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic trst, input logic [4:0] texp, input int id);
    @(negedge clk);
    reset     = trst;
    fa_if.a   = ~ta;
    fa_if.b   = tb ^ 4'h5;
    fa_if.cin = ~tc;
    #1;
    if (have_last) check_hold(id);
    fa_if.a   = ta;
    fa_if.b   = tb;
    fa_if.cin = tc;
    #1;
    if (have_last) check_hold(id);
    exp_q.push_back(texp);
    id_q.push_back(id);
    last_exp  = texp;
    have_last = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    fa_if.a   = 4'h0;
    fa_if.b   = 4'h0;
    fa_if.cin = 1'b0;

    // 1: reset for two edges with arbitrary operands, then release on zeros
    apply(4'hA, 4'h7, 1'b1, 1'b1, 5'b0_0000, 1);
    apply(4'hF, 4'hF, 1'b1, 1'b1, 5'b0_0000, 2);
    apply(4'h0, 4'h0, 1'b0, 1'b0, 5'b0_0000, 3);
    // 2, 3: small sums
    apply(4'b0001, 4'b0001, 1'b0, 1'b0, 5'b0_0010, 4);
    apply(4'b0011, 4'b0011, 1'b0, 1'b0, 5'b0_0110, 5);
    apply(4'b0111, 4'b0011, 1'b0, 1'b0, 5'b0_1010, 6);
    // 4: overflow and full carry ripple
    apply(4'b1111, 4'b1011, 1'b0, 1'b0, 5'b1_1010, 7);
    apply(4'b1111, 4'b0000, 1'b1, 1'b0, 5'b1_0000, 8);
    apply(4'b1111, 4'b1111, 1'b1, 1'b0, 5'b1_1111, 9);
    apply(4'b1000, 4'b1000, 1'b0, 1'b0, 5'b1_0000, 10);
    // 5: back-to-back stream with a reset in the middle
    apply(4'b0101, 4'b0110, 1'b1, 1'b0, 5'b0_1100, 11);
    apply(4'b1001, 4'b0111, 1'b0, 1'b0, 5'b1_0000, 12);
    apply(4'b1110, 4'b1101, 1'b1, 1'b1, 5'b0_0000, 13);
    apply(4'b0010, 4'b0100, 1'b1, 1'b0, 5'b0_0111, 14);
    apply(4'b1100, 4'b0011, 1'b0, 1'b0, 5'b0_1111, 15);
    apply(4'b1100, 4'b0011, 1'b1, 1'b0, 5'b1_0000, 16);
    // 6: exhaustive sweep
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] e;
      v = i[8:0];
      e = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0, v[8]};
      apply(v[3:0], v[7:4], v[8], 1'b0, e, 100 + i);
    end

    @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
